imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory. The datapath only reads that memory, word-addressed by PC bits [8:2], 128 words.
- Accepts a framed byte stream from a host-side byte source (UART/JTAG bridge) and assembles big-endian 32-bit words.
- Writes each word into the instruction memory write port and holds the CPU in reset until a load completes with a valid checksum.

Parameters:
- ADDR_W, 7, instruction memory word-address width (matches PC bits [8:2]).
- DEPTH, 128, maximum number of words accepted; must equal 2**ADDR_W.
- HOLD_AT_RESET, 1, when 1, cpu_rst is asserted out of reset until the first successful load; when 0, it is deasserted out of reset.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts byte_data this cycle.
- wr_en  out  1  instruction memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  word address of the write.
- wr_data  out  32  word to write.
- cpu_rst  out  1  active-high reset to PC/datapath.
- busy  out  1  load in progress.
- done  out  1  last load succeeded; sticky until next start.
- err  out  1  last load failed; sticky until next start.

Behaviour:
- Frame format:
  - Byte 0: word count N. Legal range 1..DEPTH; value 0 or N>DEPTH is an error.
  - Next 4N bytes: data words, MSB first.
  - Final byte: checksum, equal to the XOR of all 4N data bytes.
- Transfer rule: a byte is accepted only on a cycle where byte_valid && byte_ready. The source must hold byte_data stable while byte_valid && !byte_ready.
- Reset values:
  - state IDLE.
  - byte_ready=0, wr_en=0, wr_addr=0, wr_data=0.
  - busy=0, done=0, err=0.
  - cpu_rst=HOLD_AT_RESET.
  - Internal word counter, byte index and checksum accumulator cleared.
- States:
  - IDLE: byte_ready=0. On start: cpu_rst=1, busy=1, done=0, err=0, clear counters and checksum, go to COUNT.
  - COUNT: byte_ready=1. On accept: if byte is 0 or >DEPTH go to ERROR; else latch N and go to DATA.
  - DATA: byte_ready=1. On accept, shift the byte into the word register (first byte lands in [31:24]), XOR it into the checksum, and increment the byte index (0..3). On the 4th byte go to WRITE.
  - WRITE: byte_ready=0. wr_en=1 for exactly one cycle, with wr_addr = word index and wr_data = assembled word. Then increment the word index: if it equals N go to CHECK, else go to DATA.
  - CHECK: byte_ready=1. On accept: if byte == checksum go to DONE, else go to ERROR.
  - DONE: busy=0, done=1, cpu_rst=0.
  - ERROR: busy=0, err=1, cpu_rst=1. Words already written stay in memory; the CPU remains held.
- Latency:
  - wr_en asserts the cycle after the 4th byte of a word is accepted.
  - Peak throughput is 4 bytes per 5 cycles.
  - done asserts the cycle after the checksum byte is accepted.
- Boundary conditions:
  - start while busy is ignored.
  - byte_valid in IDLE, DONE or ERROR is not accepted (byte_ready=0).
  - N=DEPTH: the last write goes to wr_addr=DEPTH-1; the word index never wraps.
  - A stall of any length with byte_valid low in any state causes no state change and no timeout.
  - Asynchronous rst mid-load: immediate return to reset values. With HOLD_AT_RESET=1 the CPU stays held; the partially loaded memory is not cleared.
  - start on the same cycle as byte_valid in DONE/ERROR: start is taken and that byte is not accepted.
- Arithmetic:
  - Word index width is ADDR_W+1, so the comparison against N=DEPTH is exact.
  - Checksum is an 8-bit XOR.

Test Plan:
1. Reset, then start; stream 01, 20,08,00,05, checksum 2D -> one wr_en with addr 0 and data 0x20080005; then done=1, cpu_rst=0, err=0.
2. N=3 with words 0x8C010000, 0xAC010004, 0x10000000 and correct checksum -> wr_en at addresses 0,1,2 with matching data, each exactly one cycle after its 4th byte.
3. Count byte 00, and separately count byte 0x81 -> ERROR after that byte; err=1, cpu_rst=1, no wr_en.
4. Frame as in test 1 but checksum 2C -> word still written at addr 0; then err=1, done=0, cpu_rst=1.
5. byte_valid toggled randomly with 1-7 idle cycles inside a word, plus start pulses mid-load -> identical writes to the no-stall run; mid-load start has no effect.
6. Assert rst after the 2nd data byte, then start a fresh N=1 load -> all outputs at reset values while rst is high; the new load writes only the new word at addr 0 and completes with done=1.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write/status bundle
interface imem_loader_if #(parameter int ADDR_W = 7);
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;
  modport master (output start, byte_valid, byte_data,
                  input  byte_ready, wr_en, wr_addr, wr_data, cpu_rst, busy, done, err);
  modport slave  (input  start, byte_valid, byte_data,
                  output byte_ready, wr_en, wr_addr, wr_data, cpu_rst, busy, done, err);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: framed byte stream to big-endian instruction words with checksum-gated CPU reset
module imem_loader #(
  parameter int ADDR_W        = 7,
  parameter int DEPTH         = 128,
  parameter int HOLD_AT_RESET = 1
) (
  input logic         clk,
  input logic         rst,
  imem_loader_if.slave bus
);
  localparam int IW = ADDR_W + 1;
  typedef enum logic [2:0] {IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERROR} state_t;
  state_t        state, nxt;
  logic [IW-1:0] n, widx;
  logic [1:0]    bidx;
  logic [7:0]    csum;
  logic [31:0]   word;
  logic          acc, start_ok;
  assign bus.byte_ready = state inside {COUNT, DATA, CHECK};
  assign acc            = bus.byte_valid && bus.byte_ready;
  assign start_ok       = bus.start && (state inside {IDLE, DONE, ERROR});
  assign bus.wr_en      = state == WRITE;
  assign bus.wr_addr    = widx[ADDR_W-1:0];
  assign bus.wr_data    = word;
  assign bus.busy       = state inside {COUNT, DATA, WRITE, CHECK};
  assign bus.done       = state == DONE;
  assign bus.err        = state == ERROR;
  // only the pre-first-load IDLE follows HOLD_AT_RESET; every later non-DONE state holds the CPU
  assign bus.cpu_rst    = state == DONE ? 1'b0 : state == IDLE ? (HOLD_AT_RESET != 0) : 1'b1;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= nxt;
  // frame sequencing: count, data bytes, one-cycle write per word, checksum
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERROR: nxt = start_ok ? COUNT : state;
      COUNT: nxt = !acc ? COUNT : (bus.byte_data == '0 || 32'(bus.byte_data) > DEPTH) ? ERROR : DATA;
      DATA:  nxt = (acc && bidx == 2'd3) ? WRITE : DATA;
      WRITE: nxt = (widx + IW'(1) == n) ? CHECK : DATA;
      CHECK: nxt = !acc ? CHECK : (bus.byte_data == csum) ? DONE : ERROR;
      default: nxt = IDLE;
    endcase
  end
  // word assembly, checksum accumulation and word/byte indices
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      n    <= '0;
      widx <= '0;
      bidx <= '0;
      csum <= '0;
      word <= '0;
    end else begin
      if (start_ok) begin
        widx <= '0;
        bidx <= '0;
        csum <= '0;
      end
      if (acc && state == COUNT) n <= IW'(bus.byte_data);
      if (acc && state == DATA) begin
        word <= {word[23:0], bus.byte_data};
        csum <= csum ^ bus.byte_data;
        bidx <= bidx + 2'd1;
      end
      if (state == WRITE) widx <= widx + IW'(1);
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frames against a frame-level reference with a write scoreboard
module tb_imem_loader;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  logic [31:0] wbuf [0:DEPTH-1];
  logic [38:0] exp_q [$];
  logic prev_acc = 0;
  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();
  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .HOLD_AT_RESET(1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // monitor: every write must match the next expected word and follow an accepted byte
  always @(negedge clk) begin
    if (!rst && bus.wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: got addr %h data %h expected no write", bus.wr_addr, bus.wr_data);
      end else begin
        logic [38:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.wr_addr), 32'(e[38:32]));
        chk("wr_data", bus.wr_data, e[31:0]);
        chk("wr_lat", 32'(prev_acc), 32'd1);
      end
    end
    prev_acc = bus.byte_valid && bus.byte_ready;
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input bit stall, input bit mid);
    if (stall && $urandom_range(0, 1) == 1)
      repeat ($urandom_range(1, 7)) begin
        bus.start = mid && $urandom_range(0, 3) == 0;
        cyc();
      end
    bus.start = 0;
    bus.byte_valid = 1;
    bus.byte_data = b;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (bus.byte_ready) break;
      if (t > 20) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout: got byte_ready 0 expected 1 within 20 cycles");
        break;
      end
    end
    cyc();
    bus.byte_valid = 0;
  endtask
  task automatic run_frame(input int n, input bit bad, input bit stall, input bit swv);
    logic [7:0] cs, byt;
    bit ok;
    cs = 0;
    if (swv) begin
      bus.start = 1;
      bus.byte_valid = 1;
      bus.byte_data = 8'hAA;
      @(negedge clk);
      chk("start_vs_byte_ready", 32'(bus.byte_ready), 32'd0);
      cyc();
      bus.start = 0;
      bus.byte_valid = 0;
    end else begin
      bus.start = 1;
      cyc();
      bus.start = 0;
    end
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    send(8'(n), stall, 0);
    ok = n >= 1 && n <= DEPTH && !bad;
    if (n >= 1 && n <= DEPTH) begin
      for (int i = 0; i < n; i++)
        for (int b = 0; b < 4; b++) begin
          byt = 8'(wbuf[i] >> (24 - 8 * b));
          cs ^= byt;
          if (b == 3) exp_q.push_back({7'(i), wbuf[i]});
          send(byt, stall, stall);
        end
      send(bad ? cs ^ 8'h01 : cs, stall, stall);
    end
    chk("done", 32'(bus.done), 32'(ok));
    chk("err", 32'(bus.err), 32'(!ok));
    chk("cpu_rst", 32'(bus.cpu_rst), 32'(!ok));
    chk("busy_end", 32'(bus.busy), 32'd0);
  endtask
  task automatic chk_reset_vals();
    chk("rv_byte_ready", 32'(bus.byte_ready), 32'd0);
    chk("rv_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rv_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rv_wr_data", bus.wr_data, 32'd0);
    chk("rv_busy", 32'(bus.busy), 32'd0);
    chk("rv_done", 32'(bus.done), 32'd0);
    chk("rv_err", 32'(bus.err), 32'd0);
    chk("rv_cpu_rst", 32'(bus.cpu_rst), 32'd1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start = 0;
    bus.byte_valid = 0;
    bus.byte_data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    rst = 0;
    bus.byte_valid = 1;
    bus.byte_data = 8'h01;
    repeat (2) cyc();
    chk("idle_ready", 32'(bus.byte_ready), 32'd0);
    bus.byte_valid = 0;
    wbuf[0] = 32'h20080005;
    run_frame(1, 0, 0, 0);
    wbuf[0] = 32'h8C010000; wbuf[1] = 32'hAC010004; wbuf[2] = 32'h10000000;
    run_frame(3, 0, 0, 0);
    bus.byte_valid = 1;
    bus.byte_data = 8'h55;
    repeat (3) cyc();
    chk("done_ready", 32'(bus.byte_ready), 32'd0);
    chk("done_hold", 32'(bus.done), 32'd1);
    bus.byte_valid = 0;
    run_frame(0, 0, 0, 1);
    run_frame(8'h81, 0, 0, 0);
    wbuf[0] = 32'h20080005;
    run_frame(1, 1, 0, 0);
    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) wbuf[i] = $urandom;
      run_frame(n, $urandom_range(0, 3) == 0, 1, k == 2);
    end
    for (int i = 0; i < DEPTH; i++) wbuf[i] = $urandom;
    run_frame(DEPTH, 0, 1, 0);
    wbuf[0] = 32'h12345678; wbuf[1] = 32'h9ABCDEF0;
    bus.start = 1;
    cyc();
    bus.start = 0;
    send(8'd2, 0, 0);
    exp_q.push_back({7'd0, wbuf[0]});
    for (int b = 0; b < 4; b++) send(8'(wbuf[0] >> (24 - 8 * b)), 0, 0);
    send(8'h9A, 0, 0);
    send(8'hBC, 0, 0);
    rst = 1;
    #2;
    chk_reset_vals();
    cyc();
    rst = 0;
    wbuf[0] = 32'hDEADBEEF;
    run_frame(1, 0, 1, 0);
    repeat (3) cyc();
    chk("q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
